// File: rtl/eig_sched.sv
// eig_sched: round-robin scheduler sharing one eig_core datapath between N requester channels.
// Optional WAIT-state abort after TIMEOUT_CYCLES when the EIG_SCHED_TIMEOUT_EN macro is defined.
module eig_sched #(
  parameter int N              = 4,
  parameter int CHW            = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [N*32-1:0] req_a0,
  input  logic [N*32-1:0] req_a1,
  output logic            core_start,
  output logic [31:0]     core_a0,
  output logic [31:0]     core_a1,
  input  logic            core_done,
  input  logic [31:0]     core_kappa,
  input  logic [31:0]     core_inv_kappa,
  input  logic [2:0]      core_regime,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [CHW-1:0]  res_ch,
  output logic [31:0]     res_kappa,
  output logic [31:0]     res_inv_kappa,
  output logic [2:0]      res_regime,
  output logic            res_timeout,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  if (CHW != $clog2(N) || N < 2 || N > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("eig_sched: illegal parameter combination");
  end

  state_t         state_r;
  state_t         state_s;
  logic [CHW-1:0] ptr_r;
  logic [CHW-1:0] ptr_s;
  logic [CHW:0]   pick_s;
  logic [CHW-1:0] grant_s;
  logic           grant_vld_s;
  logic           take_s;
  logic           cap_s;
  logic           abort_s;
  logic           tmo_hit_s;
  logic [31:0]    a0_arr [N];
  logic [31:0]    a1_arr [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign a0_arr[i] = req_a0[32*i +: 32];
    assign a1_arr[i] = req_a1[32*i +: 32];
  end

  // Lowest offset from the pointer wins; scanning offsets downward lets the last hit stand.
  function automatic logic [CHW:0] rr_pick(input logic [N-1:0] vld, input logic [CHW-1:0] start);
    logic [CHW:0]   pick;
    logic [CHW-1:0] idx;
    pick = {(CHW+1){1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      idx = CHW'((int'(start) + k) % N);
      if (vld[idx]) begin
        pick = {1'b1, idx};
      end
    end
    return pick;
  endfunction

  assign pick_s      = rr_pick(req_valid, ptr_r);
  assign grant_vld_s = pick_s[CHW];
  assign grant_s     = pick_s[CHW-1:0];

`ifdef EIG_SCHED_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] wcnt_r;

  assign tmo_hit_s = (wcnt_r == TCW'(TIMEOUT_CYCLES - 1));

  // Age of the current WAIT visit; held at zero in every other state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_r <= {TCW{1'b0}};
    end else if (ena) begin
      if (state_r == WAIT) begin
        wcnt_r <= wcnt_r + TCW'(1);
      end else begin
        wcnt_r <= {TCW{1'b0}};
      end
    end
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Next-state decode, combinational grant and core issue pulse
  always_comb begin
    state_s    = state_r;
    ptr_s      = ptr_r;
    req_ready  = {N{1'b0}};
    core_start = 1'b0;
    take_s     = 1'b0;
    cap_s      = 1'b0;
    abort_s    = 1'b0;
    if (ena && rst_n) begin
      case (state_r)
        IDLE: begin
          if (grant_vld_s) begin
            req_ready[grant_s] = 1'b1;
            take_s             = 1'b1;
            ptr_s              = (grant_s == CHW'(N - 1)) ? {CHW{1'b0}} : grant_s + CHW'(1);
            state_s            = ISSUE;
          end else begin
            state_s = IDLE;
          end
        end
        ISSUE: begin
          core_start = 1'b1;
          state_s    = WAIT;
        end
        WAIT: begin
          if (core_done) begin
            cap_s   = 1'b1;
            state_s = OUT;
          end else if (tmo_hit_s) begin
            abort_s = 1'b1;
            state_s = OUT;
          end else begin
            state_s = WAIT;
          end
        end
        OUT: begin
          if (res_ready) begin
            state_s = IDLE;
          end else begin
            state_s = OUT;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // FSM state and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ptr_r   <= {CHW{1'b0}};
    end else if (ena) begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
    end
  end

  // Request latch, result capture and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_a0       <= 32'd0;
      core_a1       <= 32'd0;
      res_ch        <= {CHW{1'b0}};
      res_kappa     <= 32'd0;
      res_inv_kappa <= 32'd0;
      res_regime    <= 3'd0;
      res_timeout   <= 1'b0;
      res_valid     <= 1'b0;
      busy          <= 1'b0;
    end else if (ena) begin
      if (take_s) begin
        core_a0 <= a0_arr[grant_s];
        core_a1 <= a1_arr[grant_s];
        res_ch  <= grant_s;
      end
      if (cap_s) begin
        res_kappa     <= core_kappa;
        res_inv_kappa <= core_inv_kappa;
        res_regime    <= core_regime;
        res_timeout   <= 1'b0;
      end else if (abort_s) begin
        res_kappa     <= 32'd0;
        res_inv_kappa <= 32'd0;
        res_regime    <= 3'd0;
        res_timeout   <= 1'b1;
      end
      res_valid <= (state_s == OUT);
      busy      <= (state_s != IDLE);
    end
  end

endmodule

// File: tb/tb_eig_sched.sv
// Self-checking bench for eig_sched: randomized channel traffic, a behavioural core model,
// and a scoreboard of expected results compared by an independent monitor.
`timescale 1ns/1ps
module tb_eig_sched;
  localparam int N   = 4;
  localparam int CHW = 2;
  localparam int TMO = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ena;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a0;
  logic [N*32-1:0] req_a1;
  logic            core_start;
  logic [31:0]     core_a0;
  logic [31:0]     core_a1;
  logic            core_done;
  logic [31:0]     core_kappa;
  logic [31:0]     core_inv_kappa;
  logic [2:0]      core_regime;
  logic            res_valid;
  logic            res_ready;
  logic [CHW-1:0]  res_ch;
  logic [31:0]     res_kappa;
  logic [31:0]     res_inv_kappa;
  logic [2:0]      res_regime;
  logic            res_timeout;
  logic            busy;

  always #5 clk = ~clk;

  eig_sched #(.N(N), .CHW(CHW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .req_valid(req_valid), .req_ready(req_ready), .req_a0(req_a0), .req_a1(req_a1),
    .core_start(core_start), .core_a0(core_a0), .core_a1(core_a1),
    .core_done(core_done), .core_kappa(core_kappa), .core_inv_kappa(core_inv_kappa),
    .core_regime(core_regime),
    .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch), .res_kappa(res_kappa),
    .res_inv_kappa(res_inv_kappa), .res_regime(res_regime), .res_timeout(res_timeout),
    .busy(busy)
  );

  // Behavioural core: kappa = a0/2 (arithmetic), inv_kappa = a1, regime = a0[18:16] ^ a1[2:0]
  function automatic logic [31:0] ref_kappa(input logic [31:0] a0);
    return {a0[31], a0[31:1]};
  endfunction
  function automatic logic [2:0] ref_regime(input logic [31:0] a0, input logic [31:0] a1);
    return a0[18:16] ^ a1[2:0];
  endfunction

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic [31:0]    kappa;
    logic [31:0]    inv;
    logic [2:0]     regime;
    logic           tmo;
  } exp_t;

  // Driver-owned
  logic [31:0] d_a0 [N];
  logic [31:0] d_a1 [N];
  int  acc_seen [N];
  int  auto_mode, core_lat, drv_err;
  bit  core_hang, spur_rand, spur_req, rand_io, final_go;

  // Monitor-owned
  exp_t sb_q [$];
  exp_t me;
  int   n_tests, n_fail, m_ptr, m_wcnt, mg, go_seq, res_cnt;
  int   acc_seq [N];
  bit   m_busy, m_start_due, m_wait, m_out, final_done;
  logic [N-1:0] mexp;
  logic [31:0]  exp_a0, exp_a1, go_a0, go_a1;

  // Core-model-owned
  int  c_seen, c_cnt;
  bit  c_run;
  logic [31:0] c_a0, c_a1;

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign req_a0[32*i +: 32] = d_a0[i];
    assign req_a1[32*i +: 32] = d_a1[i];
  end

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Core model: completes core_lat enabled cycles after issue; optional spurious pulses
  always @(negedge clk) begin
    #1;
    core_done      = 1'b0;
    core_kappa     = $urandom;
    core_inv_kappa = $urandom;
    core_regime    = 3'($urandom_range(0, 7));
    if (!rst_n) begin
      c_run  = 1'b0;
      c_seen = go_seq;
      if (spur_req) core_done = 1'b1;
    end else begin
      if (go_seq != c_seen) begin
        c_seen = go_seq; c_run = 1'b1; c_cnt = core_lat; c_a0 = go_a0; c_a1 = go_a1;
      end
      if (c_run && ena && !core_hang) begin
        c_cnt--;
        if (c_cnt <= 0) begin
          core_done      = 1'b1;
          core_kappa     = ref_kappa(c_a0);
          core_inv_kappa = c_a1;
          core_regime    = ref_regime(c_a0, c_a1);
          c_run          = 1'b0;
        end
      end else if (!c_run && (spur_req || (spur_rand && $urandom_range(0, 7) == 0))) begin
        core_done = 1'b1;
      end
    end
  end

  // Monitor: transaction-level model of arbitration and the result scoreboard
  always @(negedge clk) begin
    #3;
    if (!rst_n) begin
      check("reset_outputs", 160'({req_ready, core_start, core_a0, core_a1, res_valid, res_ch,
            res_kappa, res_inv_kappa, res_regime, res_timeout, busy}), 160'(0));
      m_ptr = 0; m_busy = 1'b0; m_start_due = 1'b0; m_wait = 1'b0; m_out = 1'b0;
      sb_q.delete();
    end else begin
      mg = -1;
      if (!m_busy && ena) begin
        for (int k = 0; k < N; k++) begin
          if (mg < 0 && req_valid[(m_ptr + k) % N]) mg = (m_ptr + k) % N;
        end
      end
      mexp = (mg >= 0) ? (N'(1) << mg) : N'(0);
      check("req_ready", 160'(req_ready), 160'(mexp));
      check("busy", 160'(busy), 160'(m_busy));
      check("core_start", 160'(core_start), 160'(m_start_due && ena));
      if (core_start && m_start_due) begin
        check("core_a0", 160'(core_a0), 160'(exp_a0));
        check("core_a1", 160'(core_a1), 160'(exp_a1));
      end
      check("res_valid", 160'(res_valid), 160'(m_out));
      if (res_valid) begin
        if (sb_q.size() == 0) begin
          check("res_unexpected", 160'(1), 160'(0));
        end else begin
          check("res_ch", 160'(res_ch), 160'(sb_q[0].ch));
          check("res_kappa", 160'(res_kappa), 160'(sb_q[0].kappa));
          check("res_inv_kappa", 160'(res_inv_kappa), 160'(sb_q[0].inv));
          check("res_regime", 160'(res_regime), 160'(sb_q[0].regime));
          check("res_timeout", 160'(res_timeout), 160'(sb_q[0].tmo));
        end
      end
      if (m_out && res_ready && ena) begin
        if (sb_q.size() > 0) me = sb_q.pop_front();
        m_out = 1'b0; m_busy = 1'b0; res_cnt++;
      end
      if (m_wait && ena) begin
        if (core_done) begin
          m_wait = 1'b0; m_out = 1'b1;
        end
`ifdef EIG_SCHED_TIMEOUT_EN
        else if (m_wcnt == TMO - 1) begin
          m_wait = 1'b0; m_out = 1'b1;
          if (sb_q.size() > 0) begin
            me = sb_q.pop_front();
            me.kappa = 32'd0; me.inv = 32'd0; me.regime = 3'd0; me.tmo = 1'b1;
            sb_q.push_front(me);
          end
        end else begin
          m_wcnt++;
        end
`endif
      end
      if (m_start_due && ena) begin
        m_start_due = 1'b0; m_wait = 1'b1; m_wcnt = 0;
        go_a0 = exp_a0; go_a1 = exp_a1; go_seq++;
      end
      if (mg >= 0) begin
        exp_a0 = d_a0[mg]; exp_a1 = d_a1[mg];
        me.ch = CHW'(mg); me.kappa = ref_kappa(exp_a0); me.inv = exp_a1;
        me.regime = ref_regime(exp_a0, exp_a1); me.tmo = 1'b0;
        sb_q.push_back(me);
        m_ptr = (mg + 1) % N; m_busy = 1'b1; m_start_due = 1'b1;
        acc_seq[mg]++;
      end
    end
    if (final_go && !final_done) begin
      final_done = 1'b1;
      check("drain_scoreboard", 160'(sb_q.size()), 160'(0));
      check("drain_busy", 160'(busy), 160'(0));
      check("bounded_waits", 160'(drv_err), 160'(0));
      check("results_seen", 160'(res_cnt > 20), 160'(1));
    end
  end

  task automatic raise(input int i);
    req_valid[i] = 1'b1;
    d_a0[i] = $urandom;
    d_a1[i] = $urandom;
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (acc_seq[i] != acc_seen[i]) begin
        acc_seen[i] = acc_seq[i];
        req_valid[i] = 1'b0;
        if (auto_mode == 2) raise(i);
      end else if (auto_mode == 1 && !req_valid[i] && $urandom_range(0, 3) == 0) begin
        raise(i);
      end
    end
    if (rand_io) begin
      ena       = ($urandom_range(0, 9) != 0);
      res_ready = ($urandom_range(0, 2) != 0);
      core_lat  = $urandom_range(1, 6);
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) tick();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    run(n);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; req_valid = '0; res_ready = 1'b1;
    auto_mode = 0; core_lat = 3; drv_err = 0; core_hang = 1'b0;
    spur_rand = 1'b0; spur_req = 1'b0; rand_io = 1'b0; final_go = 1'b0;
    for (int i = 0; i < N; i++) begin
      d_a0[i] = 32'd0; d_a1[i] = 32'd0; acc_seen[i] = 0;
    end
    run(3);
    rst_n = 1'b1;

    // Single request on channel 2 with a 10-cycle core
    core_lat = 10;
    req_valid[2] = 1'b1; d_a0[2] = 32'h0001_0000; d_a1[2] = 32'h0002_0000;
    run(25);

    // Round-robin with every channel valid from reset
    do_reset(2);
    auto_mode = 2; core_lat = 3;
    for (int i = 0; i < N; i++) raise(i);
    run(60);
    auto_mode = 0;
    req_valid = '0;
    run(20);

    // Output backpressure with competing requests
    res_ready = 1'b0; core_lat = 2;
    raise(1); raise(3);
    begin
      int w = 0;
      while (!res_valid && w < 50) begin tick(); w++; end
      if (w >= 50) drv_err++;
    end
    run(20);
    res_ready = 1'b1;
    run(30);

    // Enable gap while in ISSUE
    raise(0);
    begin
      int w = 0;
      int prev = acc_seen[0];
      while (acc_seen[0] == prev && w < 50) begin tick(); w++; end
      if (w >= 50) drv_err++;
    end
    ena = 1'b0;
    run(5);
    ena = 1'b1;
    run(30);

    // Core that never completes: timeout abort or indefinite WAIT
    core_hang = 1'b1;
    raise(2);
    run(80);
    do_reset(2);

    // Reset in WAIT with core_done pulsing during reset; pointer returns to 0
    raise(2);
    run(10);
    rst_n = 1'b0; spur_req = 1'b1;
    run(2);
    req_valid[3] = 1'b1; req_valid[0] = 1'b1;
    run(1);
    spur_req = 1'b0; core_hang = 1'b0; core_lat = 2;
    rst_n = 1'b1;
    run(30);

    // Randomized traffic, enable, backpressure and spurious core pulses
    auto_mode = 1; rand_io = 1'b1; spur_rand = 1'b1;
    run(2000);
    auto_mode = 0; rand_io = 1'b0; spur_rand = 1'b0;
    ena = 1'b1; res_ready = 1'b1; core_lat = 3;
    run(150);

    final_go = 1'b1;
    run(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
